// File: rtl/trace_request_queue_if.sv
// Trace request bus between the trace source and the request queue.
//   in_*       : producer entry (time, core, operation, address) with valid/ready
//   trace_done : producer has sent its last entry (level)
//   out_*      : head entry offered to the command scheduler with valid/ready
// Modports: master = trace source / scheduler side, slave = the queue.
interface trace_request_queue_if #(
    parameter int MEM_ADDR_WIDTH = 36,
    parameter int CPU_CORE_WIDTH = 4,
    parameter int MEM_OPN_WIDTH  = 3,
    parameter int TIME_WIDTH     = 32
);
    logic                      in_valid;
    logic                      in_ready;
    logic [TIME_WIDTH-1:0]     in_time;
    logic [CPU_CORE_WIDTH-1:0] in_core;
    logic [MEM_OPN_WIDTH-1:0]  in_opn;
    logic [MEM_ADDR_WIDTH-1:0] in_addr;
    logic                      trace_done;

    logic                      out_valid;
    logic                      out_ready;
    logic [TIME_WIDTH-1:0]     out_time;
    logic [CPU_CORE_WIDTH-1:0] out_core;
    logic [MEM_OPN_WIDTH-1:0]  out_opn;
    logic [MEM_ADDR_WIDTH-1:0] out_addr;

    modport master (
        output in_valid, in_time, in_core, in_opn, in_addr, trace_done, out_ready,
        input  in_ready, out_valid, out_time, out_core, out_opn, out_addr
    );

    modport slave (
        input  in_valid, in_time, in_core, in_opn, in_addr, trace_done, out_ready,
        output in_ready, out_valid, out_time, out_core, out_opn, out_addr
    );
endinterface

// File: rtl/trace_request_queue.sv
// Trace request queue: buffers decoded CPU trace entries in a FIFO and releases
// each one to the controller front end once the free-running CPU-clock counter
// reaches the entry's timestamp. Illegal operations are dropped and counted;
// timestamps that go backwards raise a sticky order error.
// Ports:
//   clk, rst_n  : CPU clock, asynchronous active-low reset
//   bus         : trace_request_queue_if.slave (entry in, head entry out)
//   cur_time    : free-running CPU cycle counter
//   count       : FIFO occupancy
//   drop_cnt    : saturating count of dropped illegal-op entries
//   order_err   : sticky, a legal timestamp went backwards
//   all_done    : trace_done seen, queue empty, no entry pending
// Optional: define TRQ_DEBUG_EN for simulation messages and a producer
// stability assertion; functional behaviour is unchanged.
module trace_request_queue #(
    parameter int MEM_ADDR_WIDTH = 36,
    parameter int CPU_CORE_WIDTH = 4,
    parameter int MEM_OPN_WIDTH  = 3,
    parameter int TIME_WIDTH     = 32,
    parameter int QUEUE_DEPTH    = 16
) (
    input  logic                           clk,
    input  logic                           rst_n,
    trace_request_queue_if.slave           bus,
    output logic [TIME_WIDTH-1:0]          cur_time,
    output logic [$clog2(QUEUE_DEPTH):0]   count,
    output logic [7:0]                     drop_cnt,
    output logic                           order_err,
    output logic                           all_done
);
    localparam int AW = $clog2(QUEUE_DEPTH);
    localparam logic [AW:0]            FULL_CNT = (AW+1)'(QUEUE_DEPTH);
    localparam logic [MEM_OPN_WIDTH-1:0] MAX_OPN = MEM_OPN_WIDTH'(2);
    // Half of the time range: an age below this means the head time has passed.
    localparam logic [TIME_WIDTH-1:0]  HALF = {1'b1, {(TIME_WIDTH-1){1'b0}}};

    logic [TIME_WIDTH-1:0]     mem_time [QUEUE_DEPTH];
    logic [CPU_CORE_WIDTH-1:0] mem_core [QUEUE_DEPTH];
    logic [MEM_OPN_WIDTH-1:0]  mem_opn  [QUEUE_DEPTH];
    logic [MEM_ADDR_WIDTH-1:0] mem_addr [QUEUE_DEPTH];

    logic [AW-1:0]         wr_ptr, rd_ptr;
    logic [TIME_WIDTH-1:0] last_time;
    logic [TIME_WIDTH-1:0] head_time;
    logic [TIME_WIDTH-1:0] age;
    logic                  done_q;
    logic                  empty, full, due, legal;
    logic                  accept, wr_en, rd_en, drop_en, done_cond;

    assign empty     = (count == '0);
    assign full      = (count == FULL_CNT);
    assign head_time = mem_time[rd_ptr];
    assign age       = cur_time - head_time;
    assign due       = (age < HALF);
    assign legal     = (bus.in_opn <= MAX_OPN);

    assign bus.in_ready  = !full;
    assign bus.out_valid = !empty && due;
    // Fields are forced to zero while empty so stale storage never leaks out.
    assign bus.out_time  = empty ? '0 : head_time;
    assign bus.out_core  = empty ? '0 : mem_core[rd_ptr];
    assign bus.out_opn   = empty ? '0 : mem_opn[rd_ptr];
    assign bus.out_addr  = empty ? '0 : mem_addr[rd_ptr];

    assign accept  = bus.in_valid && bus.in_ready;
    assign wr_en   = accept && legal;
    assign drop_en = accept && !legal;
    assign rd_en   = bus.out_valid && bus.out_ready;

    assign done_cond = bus.trace_done && empty && !bus.in_valid;
    // Rises a cycle after the condition holds, drops the moment it goes away.
    assign all_done  = done_q && done_cond;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_time[wr_ptr] <= bus.in_time;
            mem_core[wr_ptr] <= bus.in_core;
            mem_opn[wr_ptr]  <= bus.in_opn;
            mem_addr[wr_ptr] <= bus.in_addr;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_time  <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            drop_cnt  <= '0;
            order_err <= 1'b0;
            last_time <= '0;
            done_q    <= 1'b0;
        end else begin
            cur_time <= cur_time + 1'b1;
            done_q   <= done_cond;
            if (wr_en) begin
                wr_ptr    <= wr_ptr + 1'b1;
                last_time <= bus.in_time;
                // last_time resets to 0, so the first entry can never flag.
                if (bus.in_time < last_time)
                    order_err <= 1'b1;
            end
            if (rd_en)
                rd_ptr <= rd_ptr + 1'b1;
            case ({wr_en, rd_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (drop_en && drop_cnt != 8'hFF)
                drop_cnt <= drop_cnt + 1'b1;
        end
    end

`ifdef TRQ_DEBUG_EN
    logic                      stall_q;
    logic [TIME_WIDTH-1:0]     hold_time;
    logic [CPU_CORE_WIDTH-1:0] hold_core;
    logic [MEM_OPN_WIDTH-1:0]  hold_opn;
    logic [MEM_ADDR_WIDTH-1:0] hold_addr;

    always @(posedge clk) begin
        if (rst_n) begin
            if (wr_en)
                $display("ENQ t=%0d core=%0d op=%0d addr=%h",
                         bus.in_time, bus.in_core, bus.in_opn, bus.in_addr);
            if (rd_en)
                $display("DEQ t=%0d cur=%0d", head_time, cur_time);
            if (drop_en)
                $display("DROP op=%0d addr=%h", bus.in_opn, bus.in_addr);
            if (wr_en && !order_err && bus.in_time < last_time)
                $display("order error: t=%0d after t=%0d", bus.in_time, last_time);
            if (stall_q && bus.in_valid)
                assert (bus.in_time == hold_time && bus.in_core == hold_core &&
                        bus.in_opn == hold_opn && bus.in_addr == hold_addr)
                else $error("producer changed entry while stalled");
        end
        stall_q   <= rst_n && bus.in_valid && !bus.in_ready;
        hold_time <= bus.in_time;
        hold_core <= bus.in_core;
        hold_opn  <= bus.in_opn;
        hold_addr <= bus.in_addr;
    end
`endif
endmodule

// File: tb/tb_trace_request_queue.sv
// Bench for trace_request_queue. A narrow timestamp (12 bits) is used so the
// counter wrap is reachable in a short run; all other widths are the defaults.
module tb_trace_request_queue;
    localparam int TW    = 12;
    localparam int DEPTH = 16;
    localparam logic [TW-1:0] MASK = {TW{1'b1}};
    localparam int unsigned HALF_R = 1 << (TW-1);

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic [TW-1:0] cur_time;
    logic [4:0]    count;
    logic [7:0]    drop_cnt;
    logic          order_err;
    logic          all_done;

    trace_request_queue_if #(.TIME_WIDTH(TW)) bus ();

    trace_request_queue #(.TIME_WIDTH(TW), .QUEUE_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus),
        .cur_time(cur_time), .count(count), .drop_cnt(drop_cnt),
        .order_err(order_err), .all_done(all_done)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        logic [TW-1:0] t;
        logic [3:0]    c;
        logic [2:0]    o;
        logic [35:0]   a;
    } ent_t;

    ent_t          mq[$];
    logic [TW-1:0] m_cur = '0;
    int            m_drop = 0;
    bit            m_oerr = 0;
    bit            m_have_last = 0;
    logic [TW-1:0] m_last = '0;
    bit            m_doneq = 0;

    function automatic bit m_due();
        int unsigned d;
        if (mq.size() == 0) return 0;
        d = int'((m_cur - mq[0].t) & MASK);
        return d < HALF_R;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            m_cur = '0; m_drop = 0; m_oerr = 0; m_have_last = 0; m_last = '0; m_doneq = 0;
        end else begin
            bit acc, deq, emp;
            ent_t e;
            emp = (mq.size() == 0);
            acc = bus.in_valid && (mq.size() < DEPTH);
            deq = m_due() && bus.out_ready;
            m_doneq = bus.trace_done && emp && !bus.in_valid;
            if (deq) void'(mq.pop_front());
            if (acc) begin
                if (bus.in_opn <= 3'd2) begin
                    if (m_have_last && bus.in_time < m_last) m_oerr = 1;
                    m_last = bus.in_time;
                    m_have_last = 1;
                    e.t = bus.in_time; e.c = bus.in_core; e.o = bus.in_opn; e.a = bus.in_addr;
                    mq.push_back(e);
                end else if (m_drop < 255) begin
                    m_drop++;
                end
            end
            m_cur = m_cur + 1'b1;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        chk("in_ready", bus.in_ready, mq.size() < DEPTH);
        chk("count", count, mq.size());
        chk("cur_time", cur_time, m_cur);
        chk("drop_cnt", drop_cnt, m_drop);
        chk("order_err", order_err, m_oerr);
        chk("out_valid", bus.out_valid, m_due());
        chk("all_done", all_done, m_doneq && bus.trace_done && mq.size() == 0 && !bus.in_valid);
        if (mq.size() > 0) begin
            chk("out_time", bus.out_time, mq[0].t);
            chk("out_core", bus.out_core, mq[0].c);
            chk("out_opn",  bus.out_opn,  mq[0].o);
            chk("out_addr", bus.out_addr, mq[0].a);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic idle();
        bus.in_valid = 0; bus.in_time = '0; bus.in_core = '0;
        bus.in_opn = '0; bus.in_addr = '0;
    endtask

    task automatic do_reset();
        idle();
        bus.trace_done = 0; bus.out_ready = 0;
        rst_n = 0;
        repeat (2) tick();
        rst_n = 1;
    endtask

    // Call at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic enq(input logic [TW-1:0] t, input logic [3:0] c,
                       input logic [2:0] o, input logic [35:0] a);
        logic rdy;
        int k;
        bus.in_valid = 1; bus.in_time = t; bus.in_core = c; bus.in_opn = o; bus.in_addr = a;
        for (k = 0; k < 200; k++) begin
            @(negedge clk); rdy = bus.in_ready;
            @(posedge clk); #1;
            if (rdy) break;
        end
        if (k == 200) chk("enq_timeout", bus.in_ready, 1);
        idle();
    endtask

    // Returns at the first negedge with out_valid high (or after the bound).
    task automatic wait_valid(input int max_cyc, input string name);
        int k;
        k = 0;
        @(negedge clk);
        while (!bus.out_valid && k < max_cyc) begin
            @(negedge clk); k++;
        end
        if (!bus.out_valid) chk({name, "_timeout"}, bus.out_valid, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        do_reset();

        // Reset values.
        @(negedge clk); #1;
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_count", count, 0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_drop", drop_cnt, 0);
        tick();

        // First entry, due at cur_time 5.
        do_reset();
        bus.out_ready = 1;
        enq(12'd5, 4'd2, 3'd0, 36'h012345678);
        wait_valid(20, "t1");
        chk("t1_valid_time", cur_time, 5);
        chk("t1_addr", bus.out_addr, 36'h012345678);
        chk("t1_core", bus.out_core, 2);
        @(posedge clk); #1;
        chk("t1_count_after", count, 0);

        // Fill to 16 entries at time 100, then drain in order.
        bus.out_ready = 0;
        for (int i = 0; i < 16; i++) enq(12'd100, 4'(i), 3'(i % 3), 36'(i));
        @(negedge clk);
        chk("t2_full_ready", bus.in_ready, 0);
        chk("t2_full_count", count, 16);
        tick();
        bus.out_ready = 1;
        wait_valid(200, "t2");
        chk("t2_valid_time", cur_time, 100);
        for (int i = 0; i < 16; i++) begin
            chk("t2_drain_valid", bus.out_valid, 1);
            chk("t2_drain_addr", bus.out_addr, 36'(i));
            @(posedge clk); @(negedge clk);
            if (i == 0) chk("t2_ready_after_first", bus.in_ready, 1);
        end
        chk("t2_empty", count, 0);
        tick();

        // Illegal operations are dropped; counter saturates.
        enq(12'd200, 4'd1, 3'd5, 36'h1);
        enq(12'd200, 4'd1, 3'd7, 36'h2);
        @(negedge clk);
        chk("t3_count", count, 0);
        chk("t3_drop2", drop_cnt, 2);
        tick();
        bus.in_valid = 1;
        for (k = 0; k < 300; k++) begin
            bus.in_opn = 3'(3 + (k % 5));
            tick();
        end
        idle();
        @(negedge clk);
        chk("t3_drop_sat", drop_cnt, 255);
        tick();

        // Backwards timestamp: flag set, both entries still issue.
        do_reset();
        bus.out_ready = 1;
        enq(12'd50, 4'd1, 3'd0, 36'hA);
        enq(12'd20, 4'd1, 3'd1, 36'hB);
        @(negedge clk);
        chk("t4_order_err", order_err, 1);
        wait_valid(100, "t4");
        chk("t4_first_time", cur_time, 50);
        chk("t4_first_addr", bus.out_addr, 36'hA);
        @(negedge clk);
        chk("t4_second_valid", bus.out_valid, 1);
        chk("t4_second_addr", bus.out_addr, 36'hB);
        @(negedge clk);
        chk("t4_sticky", order_err, 1);
        chk("t4_count", count, 0);
        tick();

        // all_done after drain.
        do_reset();
        enq(12'd3, 4'd0, 3'd0, 36'h10);
        enq(12'd4, 4'd0, 3'd1, 36'h11);
        enq(12'd5, 4'd0, 3'd2, 36'h12);
        bus.trace_done = 1;
        @(negedge clk);
        chk("t5_not_done_yet", all_done, 0);
        tick();
        bus.out_ready = 1;
        k = 0;
        @(negedge clk);
        while (count != 0 && k < 50) begin @(negedge clk); k++; end
        chk("t5_drained", count, 0);
        chk("t5_done_same_cycle", all_done, 0);
        @(negedge clk);
        chk("t5_done_next_cycle", all_done, 1);
        tick();
        bus.in_valid = 1; bus.in_opn = 3'd6;
        #1;
        chk("t5_done_falls", all_done, 0);
        tick();
        idle();
        bus.trace_done = 0;
        bus.out_ready = 0;

        // Reset in the middle of a drain.
        enq(cur_time + 12'd30, 4'd3, 3'd0, 36'h20);
        enq(cur_time + 12'd10, 4'd3, 3'd0, 36'h21);
        enq(cur_time + 12'd40, 4'd3, 3'd0, 36'h22);
        bus.out_ready = 1;
        wait_valid(100, "t6");
        @(posedge clk); @(negedge clk);
        #2 rst_n = 0;
        #1;
        chk("t6_rst_count", count, 0);
        chk("t6_rst_time", cur_time, 0);
        chk("t6_rst_drop", drop_cnt, 0);
        chk("t6_rst_oerr", order_err, 0);
        chk("t6_rst_valid", bus.out_valid, 0);
        chk("t6_rst_ready", bus.in_ready, 1);
        chk("t6_rst_done", all_done, 0);
        tick(); tick();
        rst_n = 1;

        // Timestamp wrap: entry at 4 entered near the top of the range.
        do_reset();
        bus.out_ready = 1;
        k = 0;
        @(negedge clk);
        while (cur_time != 12'hFF0 && k < 5000) begin @(negedge clk); k++; end
        chk("t7_reached_top", cur_time, 12'hFF0);
        tick();
        enq(12'd4, 4'd7, 3'd2, 36'h55);
        wait_valid(100, "t7");
        chk("t7_wrap_time", cur_time, 4);
        chk("t7_wrap_addr", bus.out_addr, 36'h55);
        tick();

        // Randomized traffic against the model.
        do_reset();
        for (k = 0; k < 1500; k++) begin
            logic rdy;
            @(negedge clk); rdy = bus.in_ready;
            @(posedge clk); #1;
            if (!(bus.in_valid && !rdy)) begin
                bus.in_valid = ($urandom % 2) == 1;
                bus.in_time  = m_cur + TW'($urandom_range(0, 50)) - TW'(10);
                bus.in_core  = 4'($urandom);
                bus.in_opn   = (($urandom % 10) == 0) ? 3'(3 + $urandom % 5) : 3'($urandom % 3);
                bus.in_addr  = {4'($urandom), 32'($urandom)};
            end
            bus.out_ready  = ($urandom % 4) != 0;
            bus.trace_done = (k > 1400);
        end
        idle();
        bus.out_ready = 1;
        repeat (200) tick();
        @(negedge clk);
        chk("rand_drained", count, 0);
        chk("rand_all_done", all_done, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
